data_mem_if: RTL and testbench
==============================

// Module: data_mem_if
// PURPOSE
//  Data-memory bus interface and memory data register (MDR) for the multicycle MIPS datapath.
//  Sits directly upstream of the load-extraction stage: it runs one bus read/write per request from
//  the control FSM, then holds the raw read word in MDR. The load stage slices and extends MDR by
//  LoadType and address bits [1:0]. Store byte-lane steering is also done here.
// PARAMETERS
//  TIMEOUT    255  max cycles in REQ without bus_ack before the access is aborted (1..2^TIMEOUT_W-1)
//  TIMEOUT_W  8    width of the wait-state counter
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   synchronous, active-high reset
//  MemRead      in   1   read request from control FSM, sampled only in IDLE
//  MemWrite     in   1   write request from control FSM, sampled only in IDLE; wins over MemRead
//  StoreType    in   2   `StoreWord / `StoreHalfWord / `StoreByte
//  Addr         in   32  byte address (ALUOut)
//  WriteData    in   32  store data (rt register value, right-aligned)
//  MDR          out  32  memory data register, drives the load stage's MemData_i
//  MemDone      out  1   one-cycle pulse: access finished (ok or error)
//  Busy         out  1   high in every state except IDLE
//  BusErr       out  1   one-cycle pulse with MemDone: timeout abort
//  MisalignErr  out  1   one-cycle pulse with MemDone: misaligned access (tied 0 without macro)
//  bus_req      out  1   bus request, held until bus_ack
//  bus_we       out  1   1 = write
//  bus_addr     out  32  word address, {Addr[31:2],2'b00}
//  bus_be       out  4   byte-lane enables
//  bus_wdata    out  32  lane-steered write data
//  bus_rdata    in   32  read data, valid when bus_ack=1
//  bus_ack      in   1   access complete, 1-cycle pulse
// BEHAVIOUR
//  Reset: state=IDLE. MDR=0, all outputs=0, counter=0.
//  FSM states: IDLE -> REQ -> DONE -> IDLE. Any fault goes IDLE -> DONE (misalign) or REQ -> DONE (timeout).
//  IDLE: if MemWrite|MemRead, latch addr, we, be, wdata into output regs. Set bus_req=1 next cycle, go to REQ.
//  REQ: bus_req held with stable addr/be/wdata. Counter increments each cycle.
//    bus_ack=1: drop bus_req. On a read, MDR<=bus_rdata on the same edge. Go to DONE.
//    If counter==TIMEOUT-1 with no ack: drop bus_req, set BusErr, leave MDR unchanged, go to DONE.
//  DONE: MemDone=1 for exactly one cycle, then IDLE. A new request can be accepted in the following cycle.
//  Minimum latency: request at cycle 0, bus_req at 1, ack at 1 -> MDR valid and MemDone at cycle 2.
//  MDR holds its value until the next successful read. Writes never change MDR.
//  Reads: bus_be=4'b1111 for every access.
//  Writes:
//    Word: be=1111, wdata=WriteData.
//    Half: be=Addr[1]?1100:0011, wdata={2{WriteData[15:0]}}.
//    Byte: be=0001<<Addr[1:0], wdata={4{WriteData[7:0]}}.
//  Requests while Busy are ignored. bus_ack outside REQ is ignored.
//  Reset mid-access: bus_req=0 after the reset edge, and a late ack is ignored.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//    Word with Addr[1:0]!=0, or Half with Addr[0]=1, starts no bus cycle.
//    FSM goes IDLE -> DONE, MisalignErr=1 with MemDone, MDR unchanged.
//    Reads are checked with the same rule, using StoreType as the access size.
//  Not defined: MisalignErr tied 0. Ignored low bits are forced to 0 (Word ignores Addr[1:0], Half ignores Addr[0]).
// STRUCTURE
//  Fragment_Define.v holds the shared constants:
//    `StoreWord=2'b00, `StoreHalfWord=2'b01, `StoreByte=2'b10.
//    State codes `DMI_IDLE, `DMI_REQ, `DMI_DONE.
//  One combinational sub-module, store_align: (StoreType, Addr[1:0], WriteData) -> (be, wdata).
//  FSM, counter and MDR stay in data_mem_if.
// TESTING
//  1. Read 0x100, bus ack after 3 wait cycles with rdata=0xDEADBEEF -> MDR=0xDEADBEEF, MemDone at cycle 5, be=1111.
//  2. StoreByte Addr=0x103, WriteData=0x000000A5 -> be=1000, wdata=0xA5A5A5A5, bus_we=1, MDR unchanged.
//  3. StoreHalfWord Addr=0x102, WriteData=0x1234 -> be=1100, wdata=0x12341234.
//  4. Read with no ack, TIMEOUT=4 -> bus_req drops after 4 REQ cycles, BusErr=MemDone=1 same cycle, MDR unchanged.
//  5. MemRead and MemWrite together, then MemRead while Busy -> single write cycle, extra read ignored.
//     rst during REQ -> all outputs 0 next cycle.
//  6. [MISALIGN_TRAP_EN] StoreWord Addr=0x101 -> no bus_req, MisalignErr=MemDone=1 at cycle 1.
//     Without macro -> bus_addr=0x100, be=1111.

Source files
------------

// File: rtl/data_mem_if_pkg.sv
// Shared types for the data-memory bus interface: access sizes, FSM states and the latched bus command.
package data_mem_if_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef enum logic [1:0] {
    STORE_WORD = 2'b00,
    STORE_HALF = 2'b01,
    STORE_BYTE = 2'b10
  } store_type_e;

  typedef enum logic [1:0] {
    DMI_IDLE = 2'b00,
    DMI_REQ  = 2'b01,
    DMI_DONE = 2'b10
  } dmi_state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } bus_cmd_t;

  // Natural alignment rule; the undefined size code behaves as a word.
  function automatic logic is_misaligned(input store_type_e st, input logic [1:0] lo);
    logic mis;
    case (st)
      STORE_BYTE: mis = 1'b0;
      STORE_HALF: mis = lo[0];
      default:    mis = (lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/data_mem_if_store_align.sv
// Store byte-lane steering: replicates the right-aligned store data across lanes and selects enables.
module data_mem_if_store_align
  import data_mem_if_pkg::*;
(
  input  store_type_e       store_type,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] wdata,
  output logic [BE_W-1:0]   be_c,
  output logic [DATA_W-1:0] wdata_c
);

  always_comb begin
    be_c    = '1;
    wdata_c = wdata;
    case (store_type)
      STORE_HALF: begin
        be_c    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{wdata[15:0]}};
      end
      STORE_BYTE: begin
        be_c    = BE_W'(1) << addr_lo;
        wdata_c = {4{wdata[7:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_if.sv
// Data-memory bus interface and MDR: one bus access per request, read word captured in MDR.
// Optional macro MISALIGN_TRAP_EN traps misaligned word/half accesses without starting a bus cycle.
module data_mem_if
  import data_mem_if_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        StoreType,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] MDR,
  output logic              MemDone,
  output logic              Busy,
  output logic              BusErr,
  output logic              MisalignErr,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [BE_W-1:0]   bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack
);

  dmi_state_e           state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  bus_cmd_t             cmd_q, cmd_d;
  logic [DATA_W-1:0]    mdr_q, mdr_d;
  logic                 bus_req_q, bus_req_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 bus_err_q, bus_err_d;
  logic                 mis_err_q, mis_err_d;
  logic [BE_W-1:0]      be_c;
  logic [DATA_W-1:0]    wdata_c;
  logic                 misalign_c;

  data_mem_if_store_align u_store_align (
    .store_type (store_type_e'(StoreType)),
    .addr_lo    (Addr[1:0]),
    .wdata      (WriteData),
    .be_c       (be_c),
    .wdata_c    (wdata_c)
  );

`ifdef MISALIGN_TRAP_EN
  assign misalign_c = is_misaligned(store_type_e'(StoreType), Addr[1:0]);
`else
  assign misalign_c = 1'b0;
`endif

  // Next state and next register values.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    mdr_d     = mdr_q;
    bus_req_d = 1'b0;
    done_d    = 1'b0;
    bus_err_d = 1'b0;
    mis_err_d = 1'b0;
    case (state_q)
      DMI_IDLE: begin
        if (MemWrite || MemRead) begin
          if (misalign_c) begin
            state_d   = DMI_DONE;
            done_d    = 1'b1;
            mis_err_d = 1'b1;
          end else begin
            state_d     = DMI_REQ;
            bus_req_d   = 1'b1;
            cnt_d       = '0;
            cmd_d.we    = MemWrite;
            cmd_d.addr  = {Addr[ADDR_W-1:2], 2'b00};
            cmd_d.be    = MemWrite ? be_c : '1;
            cmd_d.wdata = wdata_c;
          end
        end
      end
      DMI_REQ: begin
        cnt_d = cnt_q + TIMEOUT_W'(1);
        if (bus_ack) begin
          state_d = DMI_DONE;
          done_d  = 1'b1;
          if (!cmd_q.we) mdr_d = bus_rdata;
        end else if (cnt_q == TIMEOUT_W'(TIMEOUT - 1)) begin
          state_d   = DMI_DONE;
          done_d    = 1'b1;
          bus_err_d = 1'b1;
        end else begin
          bus_req_d = 1'b1;
        end
      end
      DMI_DONE: state_d = DMI_IDLE;
      default:  state_d = DMI_IDLE;
    endcase
    busy_d = (state_d != DMI_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DMI_IDLE;
      cnt_q     <= '0;
      cmd_q     <= '0;
      mdr_q     <= '0;
      bus_req_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      bus_err_q <= 1'b0;
      mis_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      mdr_q     <= mdr_d;
      bus_req_q <= bus_req_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      bus_err_q <= bus_err_d;
      mis_err_q <= mis_err_d;
    end
  end

  assign MDR         = mdr_q;
  assign MemDone     = done_q;
  assign Busy        = busy_q;
  assign BusErr      = bus_err_q;
  assign MisalignErr = mis_err_q;
  assign bus_req     = bus_req_q;
  assign bus_we      = cmd_q.we;
  assign bus_addr    = cmd_q.addr;
  assign bus_be      = cmd_q.be;
  assign bus_wdata   = cmd_q.wdata;

endmodule

// File: tb/tb_data_mem_if.sv
// Scoreboard bench for data_mem_if: randomized requests, a bus slave model and a MemDone monitor.
module tb_data_mem_if;

  localparam int unsigned TO = 4;
  localparam int unsigned TW = 8;

  typedef struct {
    bit          we;
    bit          both;
    bit [1:0]    st;
    bit [31:0]   addr;
    bit [31:0]   wdata;
    bit          ack;
    int unsigned dly;
    bit [31:0]   rdata;
  } txn_t;

  typedef struct {
    int unsigned cyc;
    bit          bus_err;
    bit          mis;
    bit [31:0]   mdr;
  } exp_t;

  typedef struct {
    bit          we;
    bit [31:0]   addr;
    bit [3:0]    be;
    bit [31:0]   wdata;
    bit          ack;
    int unsigned dly;
    bit [31:0]   rdata;
  } plan_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite;
  logic [1:0]  StoreType;
  logic [31:0] Addr, WriteData;
  logic [31:0] MDR;
  logic        MemDone, Busy, BusErr, MisalignErr;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        bus_ack;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  bit [31:0]   mdr_model = 32'h0;
  bit          force_spur = 1'b0;
  exp_t        exp_q[$];
  plan_t       plan_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_if #(.TIMEOUT(TO), .TIMEOUT_W(TW)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .StoreType(StoreType),
    .Addr(Addr), .WriteData(WriteData), .MDR(MDR), .MemDone(MemDone), .Busy(Busy),
    .BusErr(BusErr), .MisalignErr(MisalignErr), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " MDR"},         MDR, 32'h0);
    check({tag, " MemDone"},     32'(MemDone), 32'h0);
    check({tag, " Busy"},        32'(Busy), 32'h0);
    check({tag, " BusErr"},      32'(BusErr), 32'h0);
    check({tag, " MisalignErr"}, 32'(MisalignErr), 32'h0);
    check({tag, " bus_req"},     32'(bus_req), 32'h0);
    check({tag, " bus_we"},      32'(bus_we), 32'h0);
    check({tag, " bus_addr"},    bus_addr, 32'h0);
    check({tag, " bus_be"},      32'(bus_be), 32'h0);
    check({tag, " bus_wdata"},   bus_wdata, 32'h0);
  endtask

  function automatic txn_t mk(input bit we, input bit both, input bit [1:0] st, input bit [31:0] addr,
                              input bit [31:0] wdata, input bit ack, input int unsigned dly,
                              input bit [31:0] rdata);
    txn_t t;
    t.we = we; t.both = both; t.st = st; t.addr = addr; t.wdata = wdata;
    t.ack = ack; t.dly = dly; t.rdata = rdata;
    return t;
  endfunction

  // Reference model: compute the expected bus command and completion, then drive the request.
  task automatic issue(input txn_t t);
    int unsigned size;
    int unsigned n;
    bit          mis;
    bit          ok;
    exp_t        e;
    plan_t       p;
    size = (t.st == 2'd1) ? 2 : (t.st == 2'd2) ? 1 : 4;
    mis  = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis = (t.addr % size) != 0;
`endif
    ok = t.ack && (t.dly < TO);
    if (!mis && !t.we && ok) mdr_model = t.rdata;
    e.mdr     = mdr_model;
    e.mis     = mis;
    e.bus_err = !mis && !ok;
    e.cyc     = mis ? cyc + 1 : (ok ? cyc + 2 + t.dly : cyc + 1 + TO);
    exp_q.push_back(e);
    if (!mis) begin
      p.we    = t.we;
      p.addr  = t.addr & 32'hFFFF_FFFC;
      if (!t.we || size == 4) p.be = 4'hF;
      else if (size == 2)     p.be = 4'(32'd3 << (t.addr & 32'd2));
      else                    p.be = 4'(32'd1 << (t.addr % 4));
      if (size == 4)      p.wdata = t.wdata;
      else if (size == 2) p.wdata = (t.wdata & 32'hFFFF) * 32'h0001_0001;
      else                p.wdata = (t.wdata & 32'hFF) * 32'h0101_0101;
      p.ack   = t.ack;
      p.dly   = t.dly;
      p.rdata = t.rdata;
      plan_q.push_back(p);
    end
    MemWrite  = t.we;
    MemRead   = !t.we || t.both;
    StoreType = t.st;
    Addr      = t.addr;
    WriteData = t.wdata;
    @(negedge clk);
    n = 0;
    while (exp_q.size() != 0) begin
      MemRead   = 1'($urandom_range(0, 1));
      MemWrite  = 1'($urandom_range(0, 1));
      StoreType = 2'($urandom_range(0, 2));
      Addr      = $urandom;
      WriteData = $urandom;
      @(negedge clk);
      n++;
      if (n > 4 * TO + 20) begin
        n_tests++; n_fail++;
        $display("FAIL done_wait: no MemDone after %0d cycles, required within %0d", n, 4 * TO + 20);
        exp_q.delete();
        plan_q.delete();
      end
    end
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    @(negedge clk);
  endtask

  // Bus slave: checks the command presented and acks per the plan.
  plan_t       cur;
  bit          active = 1'b0;
  bit          chk_en = 1'b0;
  int unsigned w = 0;
  always @(negedge clk) begin
    if (rst) begin
      active    = 1'b0;
      bus_ack   = 1'b0;
      bus_rdata = 32'h0;
      plan_q.delete();
    end else if (bus_req) begin
      if (!active) begin
        active = 1'b1;
        w      = 0;
        if (plan_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL bus_req: unexpected bus cycle addr 0x%08h, required none", bus_addr);
          chk_en    = 1'b0;
          cur.ack   = 1'b1;
          cur.dly   = 0;
          cur.rdata = 32'h0;
        end else begin
          cur    = plan_q.pop_front();
          chk_en = 1'b1;
        end
      end
      if (chk_en) begin
        check("bus_we", 32'(bus_we), 32'(cur.we));
        check("bus_addr", bus_addr, cur.addr);
        check("bus_be", 32'(bus_be), 32'(cur.be));
        if (cur.we) check("bus_wdata", bus_wdata, cur.wdata);
      end
      if (cur.ack && w == cur.dly) begin
        bus_ack   = 1'b1;
        bus_rdata = cur.rdata;
        active    = 1'b0;
      end else begin
        bus_ack   = 1'b0;
        bus_rdata = $urandom;
        w++;
      end
    end else begin
      active    = 1'b0;
      bus_ack   = force_spur || ($urandom_range(0, 3) == 0);
      bus_rdata = $urandom;
    end
  end

  // Completion monitor.
  exp_t e_m;
  always @(negedge clk) begin
    if (!rst) begin
      if (MemDone) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL MemDone: unexpected completion at cycle %0d, required none", cyc);
        end else begin
          e_m = exp_q.pop_front();
          check("done_cycle", cyc, e_m.cyc);
          check("BusErr", 32'(BusErr), 32'(e_m.bus_err));
          check("MisalignErr", 32'(MisalignErr), 32'(e_m.mis));
          check("MDR", MDR, e_m.mdr);
          check("Busy_in_done", 32'(Busy), 32'h1);
        end
      end else begin
        check("err_without_done", {30'h0, BusErr, MisalignErr}, 32'h0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running after %0d cycles, required to finish", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; StoreType = 2'd0; Addr = 32'h0; WriteData = 32'h0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    issue(mk(1'b0, 1'b0, 2'd0, 32'h100, 32'h0,        1'b1, 3, 32'hDEADBEEF));
    issue(mk(1'b1, 1'b0, 2'd2, 32'h103, 32'h000000A5, 1'b1, 0, 32'h0));
    issue(mk(1'b1, 1'b0, 2'd1, 32'h102, 32'h00001234, 1'b1, 1, 32'h0));
    issue(mk(1'b0, 1'b0, 2'd0, 32'h200, 32'h0,        1'b0, 0, 32'h55555555));
    issue(mk(1'b1, 1'b1, 2'd0, 32'h300, 32'hCAFEF00D, 1'b1, 2, 32'h77777777));
    issue(mk(1'b1, 1'b0, 2'd0, 32'h101, 32'h11223344, 1'b1, 0, 32'h0));
    issue(mk(1'b0, 1'b0, 2'd1, 32'h405, 32'h0,        1'b1, 0, 32'h13579BDF));
    issue(mk(1'b0, 1'b0, 2'd0, 32'h404, 32'h0,        1'b1, TO - 1, 32'h0BADF00D));
    issue(mk(1'b0, 1'b0, 2'd0, 32'h408, 32'h0,        1'b1, TO, 32'h99999999));

    for (int i = 0; i < 300; i++) begin
      txn_t t;
      t.we    = 1'($urandom_range(0, 1));
      t.both  = t.we && ($urandom_range(0, 1) == 1);
      t.st    = 2'($urandom_range(0, 2));
      t.addr  = $urandom;
      t.wdata = $urandom;
      t.ack   = ($urandom_range(0, 7) != 0);
      t.dly   = $urandom_range(0, TO + 1);
      t.rdata = $urandom;
      issue(t);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset in the middle of a bus cycle, then a late ack that must be ignored.
    plan_q.push_back('{we: 1'b0, addr: 32'h500, be: 4'hF, wdata: 32'h0, ack: 1'b0, dly: 0, rdata: 32'h0});
    MemRead = 1'b1; MemWrite = 1'b0; StoreType = 2'd0; Addr = 32'h500;
    @(negedge clk);
    MemRead = 1'b0;
    check("bus_req_before_reset", 32'(bus_req), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    rst = 1'b0;
    force_spur = 1'b1;
    mdr_model = 32'h0;
    repeat (2) @(negedge clk);
    force_spur = 1'b0;
    @(negedge clk);
    check("late_ack MDR", MDR, 32'h0);
    check("late_ack bus_req", 32'(bus_req), 32'h0);
    check("late_ack Busy", 32'(Busy), 32'h0);
    issue(mk(1'b0, 1'b0, 2'd0, 32'h600, 32'h0, 1'b1, 0, 32'h600DCAFE));

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
